// File: rtl/quad_stepper.sv
// Quadrature encoder stimulus generator: takes a direction/count step command and
// emits a glitch-free A/B quadrature sequence, holding each phase for DWELL clocks.
module quad_stepper #(
  parameter int WIDTH = 8,
  parameter int DWELL = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_count,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] position
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FINISH
  } state_t;

  localparam logic [15:0] DWELL_RELOAD = 16'(DWELL - 1);

  state_t           state;
  logic             dir_q;
  logic [WIDTH-1:0] remaining;
  logic [15:0]      dwell_cnt;

  logic             step_dir;
  logic             next_a;
  logic             next_b;
  logic [WIDTH-1:0] next_position;

  // The accept edge steps with the incoming direction; later steps use the latched one.
  always_comb begin
    step_dir = (state == IDLE) ? cmd_dir : dir_q;
    if (step_dir) begin
      next_a        = ~enc_b;
      next_b        = enc_a;
      next_position = position + WIDTH'(1);
    end else begin
      next_a        = enc_b;
      next_b        = ~enc_a;
      next_position = position + {WIDTH{1'b1}};
    end
  end

  assign busy = ~cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      remaining <= '0;
      dwell_cnt <= '0;
      enc_a     <= 1'b0;
      enc_b     <= 1'b0;
      position  <= '0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            cmd_ready <= 1'b0;
            if (cmd_count != '0) begin
              enc_a     <= next_a;
              enc_b     <= next_b;
              position  <= next_position;
              remaining <= cmd_count - WIDTH'(1);
              dwell_cnt <= DWELL_RELOAD;
              state     <= HOLD;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        HOLD: begin
          if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 16'd1;
          end else if (remaining != '0) begin
            enc_a     <= next_a;
            enc_b     <= next_b;
            position  <= next_position;
            remaining <= remaining - WIDTH'(1);
            dwell_cnt <= DWELL_RELOAD;
          end else begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
